// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generator, in-order memory request/response
// tracking with redirect squashing, and a prefetch FIFO feeding decode.
module fetch_unit #(
  parameter int unsigned     XLEN     = 16,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

  typedef enum logic {RUN, SQUASH} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   outst_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  entry_t          fifo_q [DEPTH];
  logic [CW:0]     occupancy;
  logic            req_fire;
  logic            push;
  logic            pop;

  // Issue is capped so buffered plus in-flight words never exceed the FIFO.
  assign occupancy     = {1'b0, count_q} + {1'b0, outst_q};
  assign mem_req_valid = rst_n && !redirect_valid && (occupancy < CAP);
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign push     = mem_rsp_valid && (state_q == RUN) && !redirect_valid;
  assign pop      = if_valid && if_ready && !redirect_valid;
  assign if_valid = (count_q != '0);
  assign if_pc    = if_valid ? fifo_q[rd_ptr_q].pc    : '0;
  assign if_instr = if_valid ? fifo_q[rd_ptr_q].instr : '0;

  // Squash FSM: a redirect marks every still-owed response as stale.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (redirect_valid) begin
      drop_d  = outst_q - CW'(mem_rsp_valid);
      state_d = (drop_d != '0) ? SQUASH : RUN;
    end else if ((state_q == SQUASH) && mem_rsp_valid) begin
      drop_d = drop_q - CW'(1);
      if (drop_q == CW'(1)) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // PCs, in-flight count and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      outst_q <= outst_q + CW'(req_fire) - CW'(mem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        rsp_pc_q   <= redirect_pc;
        count_q    <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc_q <= fetch_pc_q + XLEN'(1);
        end
        if (push) begin
          rsp_pc_q <= rsp_pc_q + XLEN'(1);
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{pc: rsp_pc_q, instr: mem_rsp_data};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based memory and decode-stream model,
// per-cycle output comparison plus hand-computed literal expectations.
module tb_fetch_unit;

  localparam int unsigned XLEN     = 16;
  localparam int unsigned DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [15:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data = 16'h0000;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [15:0] if_instr;
  logic [15:0] if_pc;

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       memq[$];     // accepted requests awaiting a response, in order
  logic [15:0] fq[$];       // PCs buffered for decode
  logic [15:0] dlv[$];      // PCs delivered to decode
  int          dlv_cyc[$];
  logic [15:0] m_fetch_pc;
  int          cyc, lat, n_acc, n_checks, n_fail;
  bit          rdy_rand, ifr_rand;

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return a ^ 16'hBEEF;
  endfunction

  function automatic bit model_req_valid();
    return !redirect_valid && ((fq.size() + memq.size()) < int'(DEPTH));
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_dlv(input string name, input int idx, input logic [15:0] exp);
    if (idx < dlv.size()) begin
      chk(name, dlv[idx], exp);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: delivery %0d missing, expected %h", name, idx, exp);
    end
  endtask

  task automatic check_outputs();
    chk("mem_req_valid", 16'(mem_req_valid), 16'(model_req_valid()));
    chk("mem_req_addr", mem_req_addr, m_fetch_pc);
    chk("if_valid", 16'(if_valid), 16'(fq.size() != 0));
    if (fq.size() != 0) begin
      chk("if_pc", if_pc, fq[0]);
      chk("if_instr", if_instr, instr_of(fq[0]));
    end
  endtask

  // Advance the model by the effect of the coming clock edge.
  task automatic update_model();
    bit fire, rsp, pop;
    fire = model_req_valid() && mem_req_ready;
    rsp  = mem_rsp_valid && (memq.size() != 0);
    pop  = (fq.size() != 0) && if_ready && !redirect_valid;
    if (redirect_valid) begin
      fq.delete();
      foreach (memq[i]) memq[i].stale = 1'b1;
      m_fetch_pc = redirect_pc;
    end else begin
      if (pop) begin
        dlv.push_back(fq[0]);
        dlv_cyc.push_back(cyc);
        void'(fq.pop_front());
      end
      if (rsp && !memq[0].stale) fq.push_back(memq[0].addr);
    end
    if (rsp) void'(memq.pop_front());
    if (fire) begin
      memq.push_back('{addr: m_fetch_pc, due: cyc + lat, stale: 1'b0});
      m_fetch_pc = m_fetch_pc + 16'd1;
      n_acc++;
    end
  endtask

  task automatic drive_mem();
    mem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (ifr_rand) if_ready = 1'($urandom_range(0, 1));
    if (rst_n && (memq.size() != 0) && (memq[0].due <= cyc)) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = instr_of(memq[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 16'h0000;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    update_model();
    @(posedge clk);
    cyc++;
    #1;
    redirect_valid = 1'b0;
    drive_mem();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int latency);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    if_ready = 1'b1;
    mem_req_ready = 1'b1;
    rdy_rand = 1'b0;
    ifr_rand = 1'b0;
    fq.delete();
    memq.delete();
    m_fetch_pc = RESET_PC;
    lat = latency;
    #1;
    chk("rst_req_valid", 16'(mem_req_valid), 16'd0);
    chk("rst_req_addr", mem_req_addr, RESET_PC);
    chk("rst_if_valid", 16'(if_valid), 16'd0);
    chk("rst_if_pc", if_pc, 16'h0000);
    chk("rst_if_instr", if_instr, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    n_acc = 0;
    dlv.delete();
    dlv_cyc.delete();
    drive_mem();
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    step();
  endtask

  initial begin
    bit found;
    n_checks = 0;
    n_fail = 0;

    // Streaming with 1-cycle memory.
    do_reset(1);
    steps(10);
    for (int i = 0; i < 4; i++) chk_dlv("stream_pc", i, 16'(i));
    if (dlv_cyc.size() >= 4) begin
      chk("fill_latency", 16'(dlv_cyc[0]), 16'd2);
      chk("one_per_cycle", 16'(dlv_cyc[3]), 16'd5);
    end else chk("stream_count", 16'(dlv_cyc.size()), 16'd4);

    // Decode backpressure from the start.
    do_reset(1);
    if_ready = 1'b0;
    steps(10);
    chk("bp_accepted", 16'(n_acc), 16'd4);
    chk("bp_stop", 16'(mem_req_valid), 16'd0);
    if_ready = 1'b1;
    steps(10);
    for (int i = 0; i < 5; i++) chk_dlv("bp_resume_pc", i, 16'(i));

    // Latency 3, redirect with two requests in flight.
    do_reset(3);
    steps(2);
    dlv.delete();
    do_redirect(16'h0100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if_valid) found = 1'b1;
      else step();
    end
    if (!found) chk("redir_wait", 16'(if_valid), 16'd1);
    else begin
      chk("redir_pc", if_pc, 16'h0100);
      chk("redir_instr", if_instr, 16'hBFEF);
    end
    steps(8);
    chk_dlv("redir_first", 0, 16'h0100);
    chk_dlv("redir_second", 1, 16'h0101);

    // Redirect coinciding with a response and a decode pop.
    do_reset(1);
    steps(5);
    chk("pre_flush_pc", if_pc, 16'h0003);
    dlv.delete();
    do_redirect(16'h0040);
    chk("flush_if_valid", 16'(if_valid), 16'd0);
    steps(8);
    for (int i = 0; i < 3; i++) chk_dlv("flush_stream", i, 16'h0040 + 16'(i));

    // Back-to-back redirects while squashing.
    do_reset(3);
    steps(3);
    dlv.delete();
    do_redirect(16'h0200);
    do_redirect(16'h0300);
    steps(20);
    chk_dlv("b2b_first", 0, 16'h0300);
    chk_dlv("b2b_fourth", 3, 16'h0303);
    foreach (dlv[i]) chk("b2b_stream", dlv[i], 16'h0300 + 16'(i));

    // Address wrap with random memory and decode stalls.
    do_reset(1);
    rdy_rand = 1'b1;
    ifr_rand = 1'b1;
    steps(2);
    dlv.delete();
    do_redirect(16'hFFFE);
    steps(40);
    chk_dlv("wrap0", 0, 16'hFFFE);
    chk_dlv("wrap1", 1, 16'hFFFF);
    chk_dlv("wrap2", 2, 16'h0000);
    chk_dlv("wrap3", 3, 16'h0001);

    // Asynchronous reset mid-stream, away from any clock edge.
    do_reset(1);
    steps(6);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_req_valid", 16'(mem_req_valid), 16'd0);
    chk("async_req_addr", mem_req_addr, RESET_PC);
    chk("async_if_valid", 16'(if_valid), 16'd0);
    chk("async_if_pc", if_pc, 16'h0000);
    chk("async_if_instr", if_instr, 16'h0000);
    do_reset(1);
    steps(6);
    chk_dlv("after_reset_pc", 0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
